pwm_multi_apb: RTL and testbench

- Parametrised successor to the single-channel APB PWM.
- Provides NUM_CH independent PWM channels behind one APB3 slave, each with a COUNT_W-bit counter.
- Period and duty registers are double-buffered, so updates take effect glitch-free at the period boundary.
- Adds per-channel output polarity, sticky period-wrap flags, counter readback, and PSLVERR on bad accesses. Sits on the fabric APB bus and drives the motor/servo pins.

---
 rtl/pwm_pkg.sv | 63 ++++++
 rtl/pwm_channel.sv | 77 +++++++
 rtl/pwm_multi_apb.sv | 135 +++++++++++++
 tb/tb_pwm_multi_apb.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Register map and address decode shared by the multi-channel APB PWM.
package pwm_pkg;

  localparam logic [15:0] OFF_CTRL   = 16'h0000;
  localparam logic [15:0] OFF_POL    = 16'h0004;
  localparam logic [15:0] OFF_STATUS = 16'h0008;
  localparam logic [15:0] CH_BASE    = 16'h0010;
  localparam logic [15:0] CH_STRIDE  = 16'h0010;

  localparam logic [1:0] SUB_PERIOD = 2'd0;
  localparam logic [1:0] SUB_DUTY   = 2'd1;
  localparam logic [1:0] SUB_COUNT  = 2'd2;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_CTRL,
    REG_POL,
    REG_STATUS,
    REG_PERIOD,
    REG_DUTY,
    REG_COUNT
  } reg_kind_e;

  typedef struct packed {
    logic      valid;
    logic [3:0] ch;
    reg_kind_e kind;
  } dec_t;

  // Offset is relative to BASE_ADDR; anything outside the map is returned invalid.
  function automatic dec_t decode(input logic [15:0] off, input logic [15:0] num_ch);
    dec_t d;
    logic [15:0] rel;
    logic [15:0] idx;
    d.valid = 1'b0;
    d.ch    = 4'd0;
    d.kind  = REG_NONE;
    rel = off - CH_BASE;
    idx = rel / CH_STRIDE;
    if (off[1:0] == 2'b00) begin
      if (off == OFF_CTRL) begin
        d.valid = 1'b1;
        d.kind  = REG_CTRL;
      end else if (off == OFF_POL) begin
        d.valid = 1'b1;
        d.kind  = REG_POL;
      end else if (off == OFF_STATUS) begin
        d.valid = 1'b1;
        d.kind  = REG_STATUS;
      end else if (off >= CH_BASE && idx < num_ch) begin
        d.ch = idx[3:0];
        case (rel[3:2])
          SUB_PERIOD: begin d.valid = 1'b1; d.kind = REG_PERIOD; end
          SUB_DUTY:   begin d.valid = 1'b1; d.kind = REG_DUTY;   end
          SUB_COUNT:  begin d.valid = 1'b1; d.kind = REG_COUNT;  end
          default:    ;
        endcase
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: free-running counter, double-buffered period/duty, wrap pulse, output flop.
module pwm_channel
  import pwm_pkg::*;
#(
  parameter int COUNT_W                = 32,
  parameter int DEFAULT_PERIOD_CC      = 5000,
  parameter int DEFAULT_PULSE_WIDTH_CC = 2500
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               pol_i,
  input  logic               wr_period_i,
  input  logic               wr_duty_i,
  input  logic [COUNT_W-1:0] wdata_i,
  output logic [COUNT_W-1:0] count_o,
  output logic [COUNT_W-1:0] period_o,
  output logic [COUNT_W-1:0] duty_o,
  output logic               wrap_o,
  output logic               pwm_o
);

  localparam logic [COUNT_W-1:0] DEF_PERIOD = COUNT_W'(DEFAULT_PERIOD_CC);
  localparam logic [COUNT_W-1:0] DEF_DUTY   = COUNT_W'(DEFAULT_PULSE_WIDTH_CC);

  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] stg_period_q, stg_period_d;
  logic [COUNT_W-1:0] stg_duty_q, stg_duty_d;
  logic [COUNT_W-1:0] act_period_q, act_period_d;
  logic [COUNT_W-1:0] act_duty_q, act_duty_d;
  logic               pwm_q, pwm_d;
  logic               wrap;

  assign wrap = en_i & (count_q == act_period_q);

  // Staged values only reach the active set at a wrap, or continuously while idle.
  always_comb begin
    stg_period_d = wr_period_i ? wdata_i : stg_period_q;
    stg_duty_d   = wr_duty_i   ? wdata_i : stg_duty_q;
    count_d      = count_q;
    act_period_d = act_period_q;
    act_duty_d   = act_duty_q;
    if (!en_i || wrap) begin
      count_d      = '0;
      act_period_d = stg_period_q;
      act_duty_d   = stg_duty_q;
    end else begin
      count_d = count_q + COUNT_W'(1);
    end
    pwm_d = en_i ? ((count_q < act_duty_q) ^ pol_i) : pol_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q      <= '0;
      stg_period_q <= DEF_PERIOD;
      stg_duty_q   <= DEF_DUTY;
      act_period_q <= DEF_PERIOD;
      act_duty_q   <= DEF_DUTY;
      pwm_q        <= 1'b0;
    end else begin
      count_q      <= count_d;
      stg_period_q <= stg_period_d;
      stg_duty_q   <= stg_duty_d;
      act_period_q <= act_period_d;
      act_duty_q   <= act_duty_d;
      pwm_q        <= pwm_d;
    end
  end

  assign count_o  = count_q;
  assign period_o = stg_period_q;
  assign duty_o   = stg_duty_q;
  assign wrap_o   = wrap;
  assign pwm_o    = pwm_q;

endmodule

// File: rtl/pwm_multi_apb.sv
// NUM_CH-channel PWM behind an APB3 slave: decode, CTRL/POL/STATUS and read mux.
module pwm_multi_apb
  import pwm_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR              = 16'h0000,
  parameter int          NUM_CH                 = 4,
  parameter int          COUNT_W                = 32,
  parameter int          DEFAULT_PERIOD_CC      = 5000,
  parameter int          DEFAULT_PULSE_WIDTH_CC = 2500
) (
  input  logic              PCLK,
  input  logic              PRESERN,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PADDR,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  input  logic              PWM_EN,
  output logic [NUM_CH-1:0] PWM_OUT
);

  localparam logic [15:0] NUM_CH_W = 16'(NUM_CH);

  logic [NUM_CH-1:0]  ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]  pol_q, pol_d;
  logic [NUM_CH-1:0]  status_q, status_d;
  logic [31:0]        prdata_q, prdata_d;
  logic [31:0]        rdata;
  logic [15:0]        offset;
  dec_t               dec;
  logic               access, err, wr;
  logic [NUM_CH-1:0]  act_en, wrap, pwm, wr_period, wr_duty;
  logic [COUNT_W-1:0] ch_count  [NUM_CH];
  logic [COUNT_W-1:0] ch_period [NUM_CH];
  logic [COUNT_W-1:0] ch_duty   [NUM_CH];
  logic               unused_bits;

  assign offset  = PADDR[15:0] - BASE_ADDR;
  assign dec     = decode(offset, NUM_CH_W);
  assign access  = PSEL & PENABLE;
  assign err     = access & (~dec.valid | (PWRITE & (dec.kind == REG_COUNT)));
  assign wr      = access & PWRITE & ~err;
  assign act_en  = ctrl_q & {NUM_CH{PWM_EN}};

  assign PSLVERR = err;
  assign PREADY  = 1'b1;
  assign PRDATA  = prdata_q;
  assign PWM_OUT = pwm;
  assign unused_bits = ^{PADDR[31:16], PWDATA};

  // A wrap in the same cycle as a W1C write keeps the flag set.
  always_comb begin
    ctrl_d    = ctrl_q;
    pol_d     = pol_q;
    status_d  = status_q;
    wr_period = '0;
    wr_duty   = '0;
    if (wr) begin
      case (dec.kind)
        REG_CTRL:   ctrl_d   = PWDATA[NUM_CH-1:0];
        REG_POL:    pol_d    = PWDATA[NUM_CH-1:0];
        REG_STATUS: status_d = status_q & ~PWDATA[NUM_CH-1:0];
        default:    ;
      endcase
    end
    for (int i = 0; i < NUM_CH; i++) begin
      wr_period[i] = wr && (dec.kind == REG_PERIOD) && (dec.ch == 4'(i));
      wr_duty[i]   = wr && (dec.kind == REG_DUTY)   && (dec.ch == 4'(i));
    end
    status_d = status_d | wrap;
  end

  always_comb begin
    rdata = '0;
    if (dec.valid) begin
      case (dec.kind)
        REG_CTRL:   rdata[NUM_CH-1:0] = ctrl_q;
        REG_POL:    rdata[NUM_CH-1:0] = pol_q;
        REG_STATUS: rdata[NUM_CH-1:0] = status_q;
        default: begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (dec.ch == 4'(i)) begin
              case (dec.kind)
                REG_PERIOD: rdata[COUNT_W-1:0] = ch_period[i];
                REG_DUTY:   rdata[COUNT_W-1:0] = ch_duty[i];
                REG_COUNT:  rdata[COUNT_W-1:0] = ch_count[i];
                default:    ;
              endcase
            end
          end
        end
      endcase
    end
    prdata_d = (PSEL & ~PENABLE) ? rdata : prdata_q;
  end

  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ctrl_q   <= '0;
      pol_q    <= '0;
      status_q <= '0;
      prdata_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      pol_q    <= pol_d;
      status_q <= status_d;
      prdata_q <= prdata_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel #(
      .COUNT_W               (COUNT_W),
      .DEFAULT_PERIOD_CC     (DEFAULT_PERIOD_CC),
      .DEFAULT_PULSE_WIDTH_CC(DEFAULT_PULSE_WIDTH_CC)
    ) u_ch (
      .clk_i      (PCLK),
      .rst_ni     (PRESERN),
      .en_i       (act_en[g]),
      .pol_i      (pol_q[g]),
      .wr_period_i(wr_period[g]),
      .wr_duty_i  (wr_duty[g]),
      .wdata_i    (PWDATA[COUNT_W-1:0]),
      .count_o    (ch_count[g]),
      .period_o   (ch_period[g]),
      .duty_o     (ch_duty[g]),
      .wrap_o     (wrap[g]),
      .pwm_o      (pwm[g])
    );
  end

endmodule

// File: tb/tb_pwm_multi_apb.sv
// Bench for pwm_multi_apb: APB responses go through a scoreboard queue, PWM waveforms are measured.
module tb_pwm_multi_apb;

  localparam int NUM_CH = 4;

  logic              PCLK = 1'b0;
  logic              PRESERN = 1'b0;
  logic              PSEL = 1'b0;
  logic              PENABLE = 1'b0;
  logic              PWRITE = 1'b0;
  logic [31:0]       PADDR = '0;
  logic [31:0]       PWDATA = '0;
  logic [31:0]       PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic              PWM_EN = 1'b0;
  logic [NUM_CH-1:0] PWM_OUT;

  int checks = 0;
  int failures = 0;

  logic [31:0] q_data[$];
  bit          q_err[$];
  bit          q_chk[$];
  string       q_name[$];

  logic [31:0] m_data;
  bit          m_err, m_chk;
  string       m_name;

  always #5 PCLK = ~PCLK;

  pwm_multi_apb #(
    .BASE_ADDR(16'h0000), .NUM_CH(NUM_CH), .COUNT_W(32),
    .DEFAULT_PERIOD_CC(5000), .DEFAULT_PULSE_WIDTH_CC(2500)
  ) dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .PWM_EN(PWM_EN), .PWM_OUT(PWM_OUT)
  );

  // Monitor: each completed APB access phase pops one expectation.
  always @(negedge PCLK) begin
    if (PSEL && PENABLE && PREADY) begin
      checks++;
      if (q_data.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected: got response at addr 0x%0h, expected none", PADDR);
      end else begin
        m_data = q_data.pop_front();
        m_err  = q_err.pop_front();
        m_chk  = q_chk.pop_front();
        m_name = q_name.pop_front();
        if ((PSLVERR !== m_err) || (m_chk && (PRDATA !== m_data))) begin
          failures++;
          $display("FAIL %s: got err=%0b data=0x%0h, expected err=%0b data=0x%0h",
                   m_name, PSLVERR, PRDATA, m_err, m_data);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge PCLK);
    #1;
  endtask

  // Called one time unit after a rising edge; leaves the bus idle one unit after the access edge.
  task automatic apb(input bit w, input logic [15:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_data, input bit exp_err, input bit chk_data,
                     input string name);
    q_data.push_back(exp_data);
    q_err.push_back(exp_err);
    q_chk.push_back(chk_data);
    q_name.push_back(name);
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = {16'h0000, addr}; PWDATA = wdata;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic wr(input logic [15:0] addr, input logic [31:0] d, input string name);
    apb(1'b1, addr, d, 32'h0, 1'b0, 1'b0, name);
  endtask

  task automatic rd(input logic [15:0] addr, input logic [31:0] exp, input string name);
    apb(1'b0, addr, 32'h0, exp, 1'b0, 1'b1, name);
  endtask

  task automatic wait_rise(input int ch, input string name);
    logic prev;
    bit   found;
    int   n;
    found = 1'b0;
    n = 0;
    @(negedge PCLK);
    prev = PWM_OUT[ch];
    while (!found && n < 20000) begin
      @(negedge PCLK);
      n++;
      found = PWM_OUT[ch] && !prev;
      prev  = PWM_OUT[ch];
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s: got no rising edge in %0d cycles, expected one", name, n);
    end
  endtask

  task automatic run_len(input int ch, input logic lvl, output int n);
    n = 0;
    while (PWM_OUT[ch] === lvl && n < 20000) begin
      n++;
      @(negedge PCLK);
    end
  endtask

  task automatic hold(input int ch, input logic lvl, input int ncyc, input string name);
    int bad;
    bad = 0;
    repeat (ncyc) begin
      @(negedge PCLK);
      if (PWM_OUT[ch] !== lvl) bad++;
    end
    chk(name, 32'(bad), 32'd0);
  endtask

  int h, l;

  initial begin
    // Reset state
    repeat (3) @(negedge PCLK);
    chk("reset_pwm_out", 32'(PWM_OUT), 32'h0);
    chk("reset_prdata", PRDATA, 32'h0);
    chk("reset_pslverr", 32'(PSLVERR), 32'h0);
    #2 PRESERN = 1'b1;
    sync();
    rd(16'h0000, 32'h0, "rst_ctrl");
    rd(16'h0004, 32'h0, "rst_pol");
    rd(16'h0008, 32'h0, "rst_status");
    rd(16'h0010, 32'd5000, "rst_period0");
    rd(16'h0014, 32'd2500, "rst_duty0");
    rd(16'h0018, 32'h0, "rst_count0");
    rd(16'h0044, 32'd2500, "rst_duty3");

    // Channel 0 with default period/duty
    PWM_EN = 1'b1;
    wr(16'h0000, 32'h1, "wr_ctrl_ch0");
    wait_rise(0, "ch0_rise");
    run_len(0, 1'b1, h);
    chk("ch0_high_len", 32'(h), 32'd2500);
    run_len(0, 1'b0, l);
    chk("ch0_low_len", 32'(l), 32'd2501);
    run_len(0, 1'b1, h);
    chk("ch0_high_len2", 32'(h), 32'd2500);
    chk("other_outputs_idle", {29'h0, PWM_OUT[3:1]}, 32'h0);
    sync();
    rd(16'h0008, 32'h1, "status_after_wrap");

    // Error responses
    apb(1'b0, 16'h001C, 32'h0, 32'h0, 1'b1, 1'b1, "rd_reserved");
    apb(1'b0, 16'h0050, 32'h0, 32'h0, 1'b1, 1'b1, "rd_ch_out_of_range");
    apb(1'b0, 16'h0002, 32'h0, 32'h0, 1'b1, 1'b1, "rd_misaligned");
    apb(1'b1, 16'h0018, 32'h1234, 32'h0, 1'b1, 1'b0, "wr_count0");
    apb(1'b1, 16'h0001, 32'hF, 32'h0, 1'b1, 1'b1, "wr_misaligned_ctrl");
    apb(1'b1, 16'h001C, 32'h77, 32'h0, 1'b1, 1'b1, "wr_reserved");
    rd(16'h0000, 32'h1, "ctrl_unchanged");
    rd(16'h0010, 32'd5000, "period0_unchanged");

    // Channel 1: staged duty change mid-period
    wr(16'h0020, 32'd9, "wr_period1");
    wr(16'h0024, 32'd4, "wr_duty1");
    wr(16'h0000, 32'h3, "wr_ctrl_ch01");
    rd(16'h0020, 32'd9, "rd_period1");
    wait_rise(1, "ch1_rise");
    fork
      run_len(1, 1'b1, h);
      begin
        sync();
        wr(16'h0024, 32'd7, "wr_duty1_mid");
      end
    join
    chk("ch1_high_cur", 32'(h), 32'd4);
    run_len(1, 1'b0, l);
    chk("ch1_low_cur", 32'(l), 32'd6);
    run_len(1, 1'b1, h);
    chk("ch1_high_next", 32'(h), 32'd7);
    run_len(1, 1'b0, l);
    chk("ch1_low_next", 32'(l), 32'd3);

    // Polarity
    sync();
    wr(16'h0000, 32'h1, "wr_ctrl_ch1_off");
    wr(16'h0004, 32'h2, "wr_pol_ch1");
    repeat (3) @(negedge PCLK);
    chk("pol_idle_level", 32'(PWM_OUT[1]), 32'h1);
    sync();
    wr(16'h0024, 32'd0, "wr_duty1_zero");
    wr(16'h0000, 32'h3, "wr_ctrl_ch1_on");
    hold(1, 1'b1, 25, "pol_duty_zero");
    sync();
    wr(16'h0024, 32'd20, "wr_duty1_20");
    repeat (15) @(negedge PCLK);
    hold(1, 1'b0, 25, "pol_duty_gt_period");
    sync();
    wr(16'h0000, 32'h1, "wr_ctrl_ch1_off2");
    wr(16'h0004, 32'h0, "wr_pol_clear");

    // STATUS write-one-to-clear against a wrap in the same cycle
    wr(16'h0000, 32'h0, "wr_ctrl_all_off");
    wr(16'h0008, 32'hF, "wr_status_clear_all");
    rd(16'h0008, 32'h0, "status_cleared");
    wr(16'h0010, 32'd0, "wr_period0_zero");
    wr(16'h0000, 32'h1, "wr_ctrl_ch0_p0");
    wr(16'h0008, 32'h1, "wr_status_on_wrap");
    rd(16'h0008, 32'h1, "status_set_wins");
    wr(16'h0000, 32'h0, "wr_ctrl_off_again");
    wr(16'h0008, 32'h1, "wr_status_no_wrap");
    rd(16'h0008, 32'h0, "status_cleared2");

    // Asynchronous reset mid-period
    wr(16'h0010, 32'd5000, "wr_period0_restore");
    wr(16'h0000, 32'h1, "wr_ctrl_ch0_again");
    repeat (100) @(negedge PCLK);
    chk("pre_reset_high", 32'(PWM_OUT[0]), 32'h1);
    #2 PRESERN = 1'b0;
    #1;
    chk("async_reset_out", 32'(PWM_OUT), 32'h0);
    chk("async_reset_prdata", PRDATA, 32'h0);
    repeat (2) @(negedge PCLK);
    #2 PRESERN = 1'b1;
    sync();
    rd(16'h0018, 32'h0, "count0_after_reset");
    rd(16'h0010, 32'd5000, "period0_after_reset");
    rd(16'h0000, 32'h0, "ctrl_after_reset");
    hold(0, 1'b0, 10, "pwm0_low_after_reset");

    repeat (3) @(negedge PCLK);
    chk("sb_drain", 32'(q_data.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
